// File: rtl/quad_encoder_if.sv
// Motion-in / quadrature-out bundle for quad_encoder.
// The master drives the motion strobes; the slave returns the phases and status.
interface quad_encoder_if #(
    parameter int unsigned ACC_W = 10
);
    logic signed [7:0]       delta;
    logic                    delta_valid;
    logic                    flush;
    logic                    A;
    logic                    B;
    logic                    busy;
    logic signed [ACC_W-1:0] pending;

    modport master (
        output delta,
        output delta_valid,
        output flush,
        input  A,
        input  B,
        input  busy,
        input  pending
    );

    modport slave (
        input  delta,
        input  delta_valid,
        input  flush,
        output A,
        output B,
        output busy,
        output pending
    );
endinterface

// File: rtl/quad_encoder.sv
// Quadrature encoder emulator: turns signed motion increments into paced A/B
// phase steps, holding not-yet-issued motion in a saturating signed accumulator.
module quad_encoder #(
    parameter int unsigned STEP_DIV = 4,
    parameter int unsigned ACC_W    = 10
) (
    input  logic          clk,
    input  logic          reset,
    quad_encoder_if.slave bus
);
    localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    // Sum must hold the accumulator plus a step and also a full-range 8-bit delta.
    localparam int unsigned SUM_W = ((ACC_W + 2) > 10) ? (ACC_W + 2) : 10;
    localparam logic [DIV_W-1:0]        DIV_RELOAD = DIV_W'(STEP_DIV - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX    = SUM_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN    = -SAT_MAX;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic [DIV_W-1:0]        r_div;
    logic [DIV_W-1:0]        w_div_nxt;
    logic                    r_a;
    logic                    r_b;
    logic                    r_busy;
    logic                    w_a_nxt;
    logic                    w_b_nxt;
    logic                    w_busy_nxt;
    logic                    w_step;
    logic                    w_fwd;
    logic signed [SUM_W-1:0] w_acc_ext;
    logic signed [SUM_W-1:0] w_delta_ext;
    logic signed [SUM_W-1:0] w_adj;
    logic signed [SUM_W-1:0] w_sum;

    // A step fires when motion is pending and the pacing divider has run out.
    always_comb begin
        w_step = (r_acc != '0) && (r_div == '0);
        w_fwd  = ~r_acc[ACC_W-1];
    end

    // Accumulator update: current value + qualified delta + step retirement.
    always_comb begin
        w_acc_ext   = {{(SUM_W - ACC_W){r_acc[ACC_W-1]}}, r_acc};
        w_delta_ext = '0;
        w_adj       = '0;
        if (bus.delta_valid) begin
            w_delta_ext = {{(SUM_W - 8){bus.delta[7]}}, bus.delta};
        end
        if (w_step) begin
            w_adj = w_fwd ? {SUM_W{1'b1}} : SUM_W'(1);
        end
        w_sum = w_acc_ext + w_delta_ext + w_adj;
    end

    // Next-state: flush wins over everything and freezes the phases.
    always_comb begin
        w_acc_nxt = r_acc;
        w_div_nxt = r_div;
        w_a_nxt   = r_a;
        w_b_nxt   = r_b;
        if (bus.flush) begin
            w_acc_nxt = '0;
            w_div_nxt = DIV_RELOAD;
        end else begin
            if (w_sum > SAT_MAX) begin
                w_acc_nxt = ACC_W'(SAT_MAX);
            end else if (w_sum < SAT_MIN) begin
                w_acc_nxt = ACC_W'(SAT_MIN);
            end else begin
                w_acc_nxt = w_sum[ACC_W-1:0];
            end

            if ((r_acc == '0) || w_step) begin
                w_div_nxt = DIV_RELOAD;
            end else begin
                w_div_nxt = r_div - DIV_W'(1);
            end

            // Forward walks 00->10->11->01; reverse is its exact inverse.
            if (w_step) begin
                if (w_fwd) begin
                    w_a_nxt = ~r_b;
                    w_b_nxt = r_a;
                end else begin
                    w_a_nxt = r_b;
                    w_b_nxt = ~r_a;
                end
            end
        end
        w_busy_nxt = (w_acc_nxt != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc  <= '0;
            r_div  <= DIV_RELOAD;
            r_a    <= 1'b0;
            r_b    <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_acc  <= w_acc_nxt;
            r_div  <= w_div_nxt;
            r_a    <= w_a_nxt;
            r_b    <= w_b_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    assign bus.A       = r_a;
    assign bus.B       = r_b;
    assign bus.busy    = r_busy;
    assign bus.pending = r_acc;

endmodule

// File: tb/tb_quad_encoder.sv
// Self-checking bench for quad_encoder (STEP_DIV=4, ACC_W=10): vector table
// through a scoreboard queue, loopback quadrature decoder, and reset sequences.
module tb_quad_encoder;
    localparam int unsigned STEP_DIV = 4;
    localparam int unsigned ACC_W    = 10;

    logic clk = 1'b0;
    logic reset;

    quad_encoder_if #(.ACC_W(ACC_W)) bus ();

    quad_encoder #(.STEP_DIV(STEP_DIV), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         pre_rst;
        bit         mark;
        bit         dec_chk;
        int         dec_exp;
        bit         dv;
        int         delta;
        bit         fl;
        logic [1:0] ab;
        int         pend;
        bit         busy;
    } vec_t;

    typedef struct {
        logic [1:0] ab;
        int         pend;
        bit         busy;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    bit   nxt_rst;
    bit   nxt_mark;

    int errors = 0;
    int checks = 0;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Loopback decoder using the forward order 00->10->11->01 as positions 0..3.
    int         dec_count   = 0;
    int         dec_illegal = 0;
    int         dec_base    = 0;
    logic [1:0] dec_prev    = 2'b00;

    function automatic int ph_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(negedge clk) begin : decoder
        int d;
        if (reset) begin
            dec_prev = {bus.A, bus.B};
        end else begin
            d = (ph_pos({bus.A, bus.B}) - ph_pos(dec_prev) + 4) % 4;
            if (d == 1)      dec_count++;
            else if (d == 3) dec_count--;
            else if (d == 2) dec_illegal++;
            dec_prev = {bus.A, bus.B};
        end
    end

    function automatic void add(input bit dv, input int d, input bit fl,
                                input logic [1:0] ab, input int pend);
        vec_t v;
        v.pre_rst = nxt_rst;
        v.mark    = nxt_mark;
        v.dec_chk = 1'b0;
        v.dec_exp = 0;
        v.dv      = dv;
        v.delta   = d;
        v.fl      = fl;
        v.ab      = ab;
        v.pend    = pend;
        v.busy    = (pend != 0);
        vecs.push_back(v);
        nxt_rst  = 1'b0;
        nxt_mark = 1'b0;
    endfunction

    function automatic void idle(input int n, input logic [1:0] ab, input int pend);
        repeat (n) add(1'b0, 0, 1'b0, ab, pend);
    endfunction

    function automatic void dec_expect(input int e);
        vecs[vecs.size() - 1].dec_chk = 1'b1;
        vecs[vecs.size() - 1].dec_exp = e;
    endfunction

    // Asynchronous reset pulse between edges, held across one negedge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_int({tag, "_rst_ab"},   int'({bus.A, bus.B}), 0);
        check_int({tag, "_rst_pend"}, int'(bus.pending), 0);
        check_int({tag, "_rst_busy"}, int'(bus.busy), 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [1:0] ab, input int pend);
        check_int({tag, "_ab"},   int'({bus.A, bus.B}), int'(ab));
        check_int({tag, "_pend"}, int'(bus.pending), pend);
        check_int({tag, "_busy"}, int'(bus.busy), (pend != 0) ? 1 : 0);
    endtask

    initial begin
        exp_t e;
        reset           = 1'b1;
        bus.delta       = '0;
        bus.delta_valid = 1'b0;
        bus.flush       = 1'b0;

        // Forward +3, with a zero-delta strobe mid-stream that must change nothing.
        nxt_rst = 1'b1; nxt_mark = 1'b1;
        add(1, 3, 0, 2'b00, 3);
        idle(1, 2'b00, 3);
        add(1, 0, 0, 2'b00, 3);
        idle(1, 2'b00, 3);
        idle(1, 2'b10, 2);
        idle(3, 2'b10, 2);
        idle(1, 2'b11, 1);
        idle(3, 2'b11, 1);
        idle(1, 2'b01, 0);
        idle(1, 2'b01, 0);
        dec_expect(3);

        // Reverse -2 from 00.
        nxt_rst = 1'b1; nxt_mark = 1'b1;
        add(1, -2, 0, 2'b00, -2);
        idle(3, 2'b00, -2);
        idle(1, 2'b01, -1);
        idle(3, 2'b01, -1);
        idle(1, 2'b11, 0);
        idle(2, 2'b11, 0);
        dec_expect(-2);

        // Collision: -1 lands on the forward step edge of +1.
        nxt_mark = 1'b1;
        add(1, 1, 0, 2'b11, 1);
        idle(3, 2'b11, 1);
        add(1, -1, 0, 2'b01, -1);
        idle(3, 2'b01, -1);
        idle(1, 2'b11, 0);
        idle(2, 2'b11, 0);
        dec_expect(0);

        // Flush with delta_valid on a step edge: pending cleared, phases frozen.
        add(1, 20, 0, 2'b11, 20);
        idle(3, 2'b11, 20);
        idle(1, 2'b01, 19);
        idle(3, 2'b01, 19);
        add(1, 5, 1, 2'b01, 0);
        idle(4, 2'b01, 0);
        add(1, 1, 0, 2'b01, 1);
        idle(3, 2'b01, 1);
        idle(1, 2'b00, 0);
        idle(1, 2'b00, 0);

        // Saturation: +127 x5 clamps at +511, then -128 floors at -511.
        nxt_rst = 1'b1;
        add(1, 127, 0, 2'b00, 127);
        add(1, 127, 0, 2'b00, 254);
        add(1, 127, 0, 2'b00, 381);
        add(1, 127, 0, 2'b00, 508);
        add(1, 127, 0, 2'b10, 511);
        add(1, -128, 0, 2'b10, 383);
        add(1, -128, 0, 2'b10, 255);
        add(1, -128, 0, 2'b10, 127);
        add(1, -128, 0, 2'b11, -2);
        add(1, -128, 0, 2'b11, -130);
        add(1, -128, 0, 2'b11, -258);
        add(1, -128, 0, 2'b11, -386);
        add(1, -128, 0, 2'b10, -511);
        add(1, -128, 0, 2'b10, -511);
        add(1, -128, 0, 2'b10, -511);
        add(0, 0, 1, 2'b10, 0);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].pre_rst) do_reset($sformatf("row%0d", i));
            if (vecs[i].mark) dec_base = dec_count;
            bus.delta_valid = vecs[i].dv;
            bus.delta       = 8'(vecs[i].delta);
            bus.flush       = vecs[i].fl;
            sb.push_back('{vecs[i].ab, vecs[i].pend, vecs[i].busy, $sformatf("row%0d", i)});
            @(posedge clk);
            #1;
            bus.delta_valid = 1'b0;
            bus.flush       = 1'b0;
            e = sb.pop_front();
            check_int({e.name, "_ab"},   int'({bus.A, bus.B}), int'(e.ab));
            check_int({e.name, "_pend"}, int'(bus.pending), e.pend);
            check_int({e.name, "_busy"}, int'(bus.busy), int'(e.busy));
            if (vecs[i].dec_chk) begin
                @(negedge clk);
                #1;
                check_int({e.name, "_decoder"}, dec_count - dec_base, vecs[i].dec_exp);
            end
        end

        // Reset mid-stream: A/B drop at once, motion discarded, no step after release.
        do_reset("mid_pre");
        bus.delta_valid = 1'b1;
        bus.delta       = 8'sd20;
        @(posedge clk);
        #1;
        bus.delta_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_state("mid_run", 2'b10, 19);
        #2;
        reset = 1'b1;
        #1;
        check_state("mid_async", 2'b00, 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_state("mid_after", 2'b00, 0);

        // Delta accepted on the very first edge after release.
        reset = 1'b1;
        #1;
        @(negedge clk);
        #1;
        reset           = 1'b0;
        bus.delta_valid = 1'b1;
        bus.delta       = -8'sd5;
        @(posedge clk);
        #1;
        bus.delta_valid = 1'b0;
        check_state("first_edge", 2'b00, -5);
        repeat (3) @(posedge clk);
        #1;
        check_state("first_hold", 2'b00, -5);
        @(posedge clk);
        #1;
        check_state("first_step", 2'b01, -4);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check_state("first_flush", 2'b01, 0);

        @(negedge clk);
        check_int("decoder_illegal", dec_illegal, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/quad_encoder.md
QUAD_ENCODER -- requirements
Module: quad_encoder

Interface
REQ-001 Parameter STEP_DIV, default 4, sets clock cycles per quadrature phase step; legal range 1..65535.
REQ-002 Parameter ACC_W, default 10, sets the signed pending-count width; legal range 4..16.
REQ-003 Port clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port delta  input  8  signed two's-complement motion increment.
REQ-006 Port delta_valid  input  1  single-cycle strobe qualifying delta.
REQ-007 Port flush  input  1  synchronous clear of pending motion.
REQ-008 Port A  output  1  quadrature phase A, registered.
REQ-009 Port B  output  1  quadrature phase B, registered.
REQ-010 Port busy  output  1  high while pending count is nonzero.
REQ-011 Port pending  output  ACC_W  signed pending step count, registered.

Function
REQ-012 The block SHALL hold a signed ACC_W accumulator acc, a divider div of width ceil(log2(STEP_DIV)) min 1, and a 2-bit phase {A,B}.
REQ-013 Forward phase order SHALL be {A,B}: 00 -> 10 -> 11 -> 01 -> 00; reverse order SHALL be the exact inverse.
REQ-014 A forward step means new A differs from previous B; a reverse step means new A equals previous B; each step changes exactly one of A, B.
REQ-015 When acc == 0, div SHALL load STEP_DIV-1 every cycle and {A,B} SHALL hold.
REQ-016 When acc != 0 and div != 0, div SHALL decrement by 1.
REQ-017 When acc != 0 and div == 0, the block SHALL issue one step (forward if acc > 0, reverse if acc < 0), reload div with STEP_DIV-1, and move acc one toward zero.
REQ-018 The first step SHALL appear on A/B exactly STEP_DIV clock edges after the edge that makes acc nonzero from zero; subsequent steps SHALL follow every STEP_DIV edges while acc stays nonzero.
REQ-019 On delta_valid, the next acc SHALL be acc + sign-extended delta + step adjustment (-1 forward, +1 reverse, 0 none), computed at ACC_W+2 bits.
REQ-020 The sum SHALL saturate symmetrically to +/-(2^(ACC_W-1)-1); the most negative code SHALL never be stored.
REQ-021 delta_valid with delta == 0 SHALL have no effect.
REQ-022 A step and delta_valid on the same edge SHALL both take effect; a sign change of acc SHALL NOT reset div.
REQ-023 flush SHALL set acc to 0 and div to STEP_DIV-1 on the next edge, SHALL take priority over delta_valid and any step, and SHALL leave {A,B} unchanged.
REQ-024 busy SHALL equal (acc != 0), and pending SHALL equal acc; both SHALL be available in the same cycle as the register value.
REQ-025 Outputs A and B SHALL be direct flip-flop outputs with no combinational path from any input.

Reset
REQ-026 Asserting reset SHALL immediately force A=0, B=0, acc=0, pending=0, busy=0, and div=STEP_DIV-1, regardless of the clock.
REQ-027 Reset asserted mid-operation SHALL discard all pending motion; no step SHALL occur on the first edge after release.
REQ-028 After reset release, the block SHALL accept delta_valid on the first clock edge.

Verification (STEP_DIV=4, ACC_W=10)
REQ-029 Reset scenario: pulse reset asynchronously between edges -> A=B=0, pending=0, busy=0 before the next edge.
REQ-030 Forward scenario: delta=+3 strobed at edge 0 -> pending=3 and busy=1 after edge 0; {A,B}=10 at edge 4, 11 at edge 8, 01 at edge 12; then pending=0 and busy=0; a loopback decoder counts +3.
REQ-031 Reverse scenario: from {A,B}=00, delta=-2 -> {A,B}=01 at edge 4, 11 at edge 8; decoder counts -2; pending returns to 0.
REQ-032 Saturation scenario: delta=+127 strobed on 5 consecutive edges -> pending=+511 and never wraps; delta=-128 repeated -> pending floors at -511.
REQ-033 Collision scenario: pending=+1 with delta=-1 strobed on the step edge -> forward step issued, pending=-1, reverse step 4 edges later, pending=0; net decoder displacement 0.
REQ-034 Flush/reset scenario: pending=+20 mid-stream, assert flush with delta_valid=1 -> pending=0 next edge and A/B frozen; repeat with async reset -> A=B=0 immediately.
